// File: rtl/lsu.sv
//==============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit; turns byte requests into word-memory
//            accesses and returns extended load data or an error.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lsu #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [4:0]    req_rd,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [4:0]    resp_rd,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [4:0]  r_rd;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Request decode is evaluated on the same cycle the request is latched.
    always_comb begin
        w_illegal  = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                               (req_funct3 == 3'b111));
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_range    = (req_addr[31:2] >= 30'(DEPTH));
        w_err      = w_illegal || w_misalign || w_range;

        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Write strobe comes straight from state so an async reset kills it at once.
    assign mem_we     = (r_state == ACCESS) && r_we;
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_lane    <= 2'd0;
            r_rd      <= 5'd0;
            resp_rd   <= 5'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_lane    <= req_addr[1:0];
                        r_rd      <= req_rd;
                        mem_addr  <= req_addr[AW+1:2];
                        mem_be    <= w_be;
                        mem_wdata <= w_wdata;
                        if (w_err) begin
                            resp_rd   <= 5'd0;
                            resp_data <= 32'd0;
                            resp_err  <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            r_state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        resp_rd   <= 5'd0;
                        resp_data <= 32'd0;
                        resp_err  <= 1'b0;
                        r_state   <= RESP;
                    end else begin
                        r_state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_rd   <= r_rd;
                    resp_data <= w_load;
                    resp_err  <= 1'b0;
                    r_state   <= RESP;
                end
                default: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
//==============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu with a behavioural data memory.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lsu;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_rd;
    logic          resp_valid;
    logic          resp_ready;
    logic [4:0]    resp_rd;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read, byte-enabled data memory.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drives one request, pushes its expected response, then waits (bounded)
    // for the response and checks it against the popped entry. Returns the
    // memory-side signals seen in the cycle after acceptance and a mask of the
    // cycles (bit n = T+n) in which mem_we was high.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [4:0] erd,
                           input logic [31:0] edata, input logic eerr,
                           input int elat, input string name,
                           output logic [AW-1:0] a1, output logic [3:0] be1,
                           output logic [31:0] wd1, output int we_mask);
        exp_t e;
        exp_t got;
        bit   seen;
        int   lat;
        e = '{erd, edata, eerr, elat};
        sb.push_back(e);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_ready: got %b want 1", name, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        we_mask   = 0;
        seen      = 1'b0;
        lat       = 0;
        a1 = '0; be1 = '0; wd1 = '0;
        for (int n = 1; n <= 8 && !seen; n++) begin
            if (n == 1) begin
                a1  = mem_addr;
                be1 = mem_be;
                wd1 = mem_wdata;
            end
            if (mem_we === 1'b1) we_mask |= (1 << n);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        got = sb.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
        end else begin
            if (lat != got.lat || resp_rd !== got.rd || resp_data !== got.data ||
                resp_err !== got.err) begin
                n_err++;
                $display("FAIL %s resp: got lat=%0d rd=%0d data=%h err=%b want lat=%0d rd=%0d data=%h err=%b",
                         name, lat, resp_rd, resp_data, resp_err,
                         got.lat, got.rd, got.data, got.err);
            end
            if (resp_ready) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        run_req(1'b1, 3'b010, 32'h10, 32'h5A5A5A5A, 5'd0, 5'd0, 32'd0, 1'b0, 2,
                "pre_reset_sw", a, be, wd, m);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rd !== 5'd0 ||
            resp_data !== 32'd0 || resp_err !== 1'b0 || mem_addr !== '0 ||
            mem_we !== 1'b0 || mem_be !== 4'd0 || mem_wdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b rv=%b rd=%0d data=%h err=%b addr=%0d we=%b be=%b wd=%h want 1 0 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rd, resp_data, resp_err,
                     mem_addr, mem_we, mem_be, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: resp_valid=%b req_ready=%b want 0 1",
                         i, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_store_word();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        run_req(1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 5'd7, 5'd0, 32'd0, 1'b0, 2,
                "sw_0x4", a, be, wd, m);
        n_vec++;
        if (a !== 7'd1 || be !== 4'b1111 || wd !== 32'hDEADBEEF || m != 2) begin
            n_err++;
            $display("FAIL sw_0x4 mem: addr=%0d be=%b wdata=%h we_mask=%0h want 1 1111 deadbeef 2",
                     a, be, wd, m);
        end
    endtask

    task automatic test_loads();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        logic [2:0]    f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0]   ad [5] = '{32'h7, 32'h7, 32'h6, 32'h6, 32'h4};
        logic [31:0]   ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                  32'h000080FF, 32'h80FF1234};
        run_req(1'b1, 3'b010, 32'h4, 32'h80FF1234, 5'd0, 5'd0, 32'd0, 1'b0, 2,
                "preload", a, be, wd, m);
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3[i], ad[i], 32'd0, 5'(i + 1), 5'(i + 1), ex[i], 1'b0, 3,
                    $sformatf("load_%0d", i), a, be, wd, m);
            n_vec++;
            if (m != 0) begin
                n_err++;
                $display("FAIL load_%0d mem_we: mask=%0h want 0", i, m);
            end
        end
    endtask

    task automatic test_store_half();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        run_req(1'b1, 3'b001, 32'h6, 32'h0000ABCD, 5'd0, 5'd0, 32'd0, 1'b0, 2,
                "sh_0x6", a, be, wd, m);
        n_vec++;
        if (a !== 7'd1 || be !== 4'b1100 || wd !== 32'hABCDABCD || m != 2) begin
            n_err++;
            $display("FAIL sh_0x6 mem: addr=%0d be=%b wdata=%h we_mask=%0h want 1 1100 abcdabcd 2",
                     a, be, wd, m);
        end
        run_req(1'b0, 3'b010, 32'h4, 32'd0, 5'd6, 5'd6, 32'hABCD1234, 1'b0, 3,
                "lw_after_sh", a, be, wd, m);
    endtask

    task automatic test_errors();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        logic          we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]    f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0]   ad [4] = '{32'h2, 32'h1, 32'h200, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_req(we[i], f3[i], ad[i], 32'hFFFFFFFF, 5'd3, 5'd0, 32'd0, 1'b1, 1,
                    $sformatf("err_%0d", i), a, be, wd, m);
            n_vec++;
            if (m != 0) begin
                n_err++;
                $display("FAIL err_%0d mem_we: mask=%0h want 0", i, m);
            end
        end
    endtask

    task automatic test_boundary();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        run_req(1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D, 5'd0, 5'd0, 32'd0, 1'b0, 2,
                "sw_0x1fc", a, be, wd, m);
        n_vec++;
        if (a !== 7'd127 || m != 2) begin
            n_err++;
            $display("FAIL sw_0x1fc mem: addr=%0d we_mask=%0h want 127 2", a, m);
        end
        run_req(1'b0, 3'b010, 32'h1FC, 32'd0, 5'd8, 5'd8, 32'hCAFEF00D, 1'b0, 3,
                "lw_0x1fc", a, be, wd, m);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            m;
        resp_ready = 1'b0;
        run_req(1'b0, 3'b010, 32'h4, 32'd0, 5'd9, 5'd9, 32'hABCD1234, 1'b0, 3,
                "bp_load", a, be, wd, m);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (resp_valid !== 1'b1 || resp_rd !== 5'd9 || resp_data !== 32'hABCD1234 ||
                resp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: rv=%b rd=%0d data=%h err=%b rdy=%b want 1 9 abcd1234 0 0",
                         i, resp_valid, resp_rd, resp_data, resp_err, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: req_ready=%b resp_valid=%b want 1 0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        req_wdata  = 32'h11111111;
        req_rd     = 5'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_vec++;
        if (mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL rst_access_pre: mem_we=%b want 1", mem_we);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_access: mem_we=%b resp_valid=%b req_ready=%b want 0 0 1",
                     mem_we, resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (resp_valid !== 1'b0 || mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL rst_access_after[%0d]: resp_valid=%b mem_we=%b want 0 0",
                         i, resp_valid, mem_we);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_errors();
        test_boundary();
        test_backpressure();
        test_reset_in_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core's memory stage. Accepts one load or store per handshake from execute, drives the word-addressed data memory, and returns sign/zero-extended load data (or an error) to writeback. Sits directly upstream of the data memory: it converts byte addresses and funct3 size codes into word addresses, byte enables and lane-aligned write data.

## Interface
- DEPTH, 128, data memory depth in 32-bit words
- AW, $clog2(DEPTH), word address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- req_rd  in  5  load destination register
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts response
- resp_rd  out  5  destination register; 0 for stores and errors
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_addr  out  AW  word address, shared by read and write
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data, valid one cycle after mem_addr (synchronous read)

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch the whole request and decode it.
  - Error -> RESP with resp_err=1.
  - Otherwise -> ACCESS.
- Error conditions, checked on the latched request:
  - Illegal funct3: 011, 110, 111 for loads; any 1xx for stores.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - req_addr[31:2] >= DEPTH.
- ACCESS: mem_addr=addr[AW+1:2].
  - Store: mem_we=1 -> RESP.
  - Load: mem_we=0 -> CAPTURE.
- CAPTURE (loads only): select lanes from mem_rdata and register the extended result -> RESP.
  - B/BU: byte addr[1:0], sign-/zero-extended.
  - H/HU: half addr[1], sign-/zero-extended.
  - W: whole word.
- RESP: resp_valid=1 with all resp_* stable; on resp_ready -> IDLE.
- Store lane rules:
  - SB: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - SH: mem_be=addr[1]?4'b1100:4'b0011, mem_wdata={2{wdata[15:0]}}.
  - SW: mem_be=4'b1111, mem_wdata=wdata.
- mem_we is decoded from the registered state only, and is asserted solely in ACCESS for a valid store; it is never asserted for errors.
- mem_addr, mem_be and mem_wdata hold their latched values outside ACCESS.

## Timing
- Request accepted in cycle T (req_valid & req_ready). Response latency:
  - Load: resp_valid first high in T+3.
  - Store: resp_valid in T+2, with mem_we high in T+1 only.
  - Error: resp_valid in T+1.
- Backpressure: with resp_ready=0, stay in RESP indefinitely with outputs unchanged and req_ready=0. Throughput is at most one request per 2 cycles (error) to 4 cycles (load).
- Response accepted in cycle R -> IDLE in R+1. A new request may not be accepted in cycle R (req_ready=0 in RESP).
- Reset values (asynchronous, immediate on rst rising):
  - State IDLE, so req_ready=1.
  - resp_valid=0, resp_rd=0, resp_data=0, resp_err=0.
  - mem_addr=0, mem_we=0, mem_be=0, mem_wdata=0.
- Reset mid-operation aborts any in-flight request. A store in ACCESS has mem_we dropped immediately and no response is produced.
- Boundary: word DEPTH-1 (addr 0x1FC at DEPTH=128) is legal; 0x200 is an error.

## Test plan
- Reset: assert rst mid-cycle -> all outputs at reset values immediately, req_ready=1; release, and no resp_valid until a request is made.
- SW addr 0x4, wdata 0xDEADBEEF -> T+1: mem_we=1, mem_addr=1, mem_be=1111, mem_wdata=0xDEADBEEF; T+2: resp_valid=1, resp_err=0, resp_rd=0.
- Preload word 1 = 0x80FF1234:
  - LB 0x7 -> resp_data 0xFFFFFF80 at T+3.
  - LBU 0x7 -> 0x00000080.
  - LH 0x6 -> 0xFFFF80FF.
  - LHU 0x6 -> 0x000080FF.
  - LW 0x4 with rd=5 -> 0x80FF1234, resp_rd=5.
- SH 0x6, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; a following LW 0x4 returns 0xABCD1234 (from the preload above).
- Errors, each -> resp_valid at T+1, resp_err=1, resp_data=0, mem_we never high:
  - LW 0x2.
  - LH 0x1.
  - SW 0x200.
  - Load with funct3 011.
- Backpressure and reset:
  - Hold resp_ready=0 for 3 cycles after a load response -> resp_* stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
  - Assert rst during ACCESS of a store -> mem_we falls immediately, no resp_valid.
